// File: rtl/act_sched_pkg.sv
// rtl/act_sched_pkg.sv - shared types and codes for the activation scheduler
package act_sched_pkg;

    // Datapath function selects, passed through to the activation stage unchanged.
    localparam logic [1:0] FUNC_RELU    = 2'd0;
    localparam logic [1:0] FUNC_SIGMOID = 2'd1;
    localparam logic [1:0] FUNC_TANH    = 2'd2;
    localparam logic [1:0] FUNC_SOFTMAX = 2'd3;

    // Response error codes.
    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_SIZE    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // A job is legal when it has at least one element and fits the datapath.
    // The comparison is unsigned 32-bit.
    function automatic logic size_ok(input logic [31:0] size, input logic [31:0] max_elems);
        return (size != 32'd0) && (size <= max_elems);
    endfunction

endpackage

// File: rtl/act_rr_arbiter.sv
// rtl/act_rr_arbiter.sv - combinational round-robin grant among pending requesters
//  req_i        : pending request vector
//  last_grant_i : id granted last; search starts one above it and wraps
//  grant_o      : one-hot grant (all zero when nothing pending)
//  grant_id_o   : encoded id of the grant
//  grant_any_o  : a grant was made
module act_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    grant_id_o,
    output logic               grant_any_o
);

    always_comb begin
        int idx;
        idx         = 0;
        grant_o     = '0;
        grant_id_o  = '0;
        grant_any_o = 1'b0;
        // Offsets 1..NUM_REQ visit every requester once, last_grant itself last.
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = int'(last_grant_i) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_any_o && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                grant_id_o   = ID_W'(idx);
                grant_any_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/activation_scheduler.sv
// rtl/activation_scheduler.sv - shares one activation datapath among NUM_REQ requesters
//  clk, rst                  : clock, synchronous active-high reset
//  req_valid/req_ready       : per-requester job handshake (req_ready one-hot, IDLE only)
//  req_func/req_size         : packed per-requester func select (2b) and element count (32b)
//  act_func_sel/act_matrix_size/act_valid_in/act_valid_out : datapath programming and handshake
//  rsp_valid/rsp_ready/rsp_id/rsp_err : completion response, held until accepted
//  busy                      : high whenever a job is in flight
module activation_scheduler
    import act_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int MAX_ELEMS = 196,
    parameter int TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [2*NUM_REQ-1:0]  req_func,
    input  logic [32*NUM_REQ-1:0] req_size,
    output logic [1:0]            act_func_sel,
    output logic [31:0]           act_matrix_size,
    output logic                  act_valid_in,
    input  logic                  act_valid_out,
    output logic                  rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output logic [1:0]            rsp_err,
    input  logic                  rsp_ready,
    output logic                  busy
);

    state_e            state_q;
    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        cnt_q;
    logic [1:0]        act_func_sel_q;
    logic [31:0]       act_matrix_size_q;
    logic              act_valid_in_q;
    logic              rsp_valid_q;
    logic [1:0]        rsp_err_q;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [1:0]         gnt_func;
    logic [31:0]        gnt_size;

    act_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (gnt),
        .grant_id_o   (gnt_id),
        .grant_any_o  (gnt_any)
    );

    // One-hot mux of the granted requester's job fields.
    always_comb begin
        gnt_func = '0;
        gnt_size = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_func = req_func[2*i +: 2];
                gnt_size = req_size[32*i +: 32];
            end
        end
    end

    // Grants are only offered in IDLE; reset suppresses them so every output reads 0.
    assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            last_grant_q      <= ID_W'(NUM_REQ - 1);
            id_q              <= '0;
            cnt_q             <= '0;
            act_func_sel_q    <= '0;
            act_matrix_size_q <= '0;
            act_valid_in_q    <= 1'b0;
            rsp_valid_q       <= 1'b0;
            rsp_err_q         <= ERR_OK;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        id_q <= gnt_id;
                        if (!size_ok(gnt_size, 32'(MAX_ELEMS))) begin
                            // Rejected jobs never touch the datapath programming.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= ERR_SIZE;
                        end else begin
                            state_q           <= ISSUE;
                            act_valid_in_q    <= 1'b1;
                            act_func_sel_q    <= gnt_func;
                            act_matrix_size_q <= gnt_size;
                        end
                    end
                end
                ISSUE: begin
                    act_valid_in_q <= 1'b0;
                    cnt_q          <= '0;
                    state_q        <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the timeout cycle still counts as success.
                    if (act_valid_out) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_OK;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= ERR_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q  <= 1'b0;
                        last_grant_q <= id_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign act_func_sel    = act_func_sel_q;
    assign act_matrix_size = act_matrix_size_q;
    assign act_valid_in    = act_valid_in_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = id_q;
    assign rsp_err         = rsp_err_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_activation_scheduler.sv
// tb/tb_activation_scheduler.sv - scoreboard bench for activation_scheduler
module tb_activation_scheduler;
    import act_sched_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int MAX_ELEMS = 196;
    localparam int TIMEOUT   = 15;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [2*NUM_REQ-1:0]  req_func;
    logic [32*NUM_REQ-1:0] req_size;
    logic [1:0]            act_func_sel;
    logic [31:0]           act_matrix_size;
    logic                  act_valid_in;
    logic                  act_valid_out;
    logic                  rsp_valid;
    logic [ID_W-1:0]       rsp_id;
    logic [1:0]            rsp_err;
    logic                  rsp_ready;
    logic                  busy;

    activation_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .ID_W      (ID_W),
        .MAX_ELEMS (MAX_ELEMS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_func        (req_func),
        .req_size        (req_size),
        .act_func_sel    (act_func_sel),
        .act_matrix_size (act_matrix_size),
        .act_valid_in    (act_valid_in),
        .act_valid_out   (act_valid_out),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_err         (rsp_err),
        .rsp_ready       (rsp_ready),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Datapath model: one register stage, optionally muted, plus a direct injection.
    logic dp_en, force_vo, dp_q;
    always @(posedge clk) begin
        if (rst) dp_q <= 1'b0;
        else     dp_q <= act_valid_in & dp_en;
    end
    assign act_valid_out = dp_q | force_vo;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   grant_id_log[$];
    int   grant_cyc_log[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   vin_count   = 0;

    function automatic exp_t mk(input int id, input logic [1:0] err);
        exp_t r;
        r.id  = 2'(id);
        r.err = err;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: counts datapath pulses, logs grants, pops the scoreboard on each response.
    always @(negedge clk) begin
        if (!rst) begin
            if (act_valid_in) vin_count++;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    grant_id_log.push_back(i);
                    grant_cyc_log.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 32'(rsp_id), 32'(e.id));
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a job on one requester and returns 1ns after its accept edge.
    task automatic issue(input int id, input logic [1:0] f, input logic [31:0] s);
        int n;
        req_valid[id]       = 1'b1;
        req_func[2*id +: 2] = f;
        req_size[32*id +: 32] = s;
        #1;
        n = 0;
        while (!req_ready[id] && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("accept_timeout", 32'd0, 32'd1);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check("idle_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b1;
        req_valid = '0;
        req_func  = '0;
        req_size  = '0;
        rsp_ready = 1'b0;
        dp_en     = 1'b1;
        force_vo  = 1'b0;
        repeat (2) step();

        // Reset state
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_func", 32'(act_func_sel), 32'd0);
        check("rst_size", act_matrix_size, 32'd0);
        check("rst_vin", 32'(act_valid_in), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        step();

        // T2 fairness from reset: 0,1,2,3,0 at one job per 4 cycles
        grant_id_log.delete();
        grant_cyc_log.delete();
        req_size = {32'd8, 32'd8, 32'd8, 32'd8};
        req_func = {FUNC_SOFTMAX, FUNC_TANH, FUNC_SIGMOID, FUNC_RELU};
        for (int k = 0; k < 5; k++) sb.push_back(mk(k % 4, ERR_OK));
        req_valid = 4'hF;
        n = 0;
        while (grant_id_log.size() < 5 && n < 60) begin
            step();
            n++;
        end
        req_valid = '0;
        check("t2_grants", 32'(grant_id_log.size()), 32'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_id_log.size())
                check($sformatf("t2_grant%0d", k), 32'(grant_id_log[k]), 32'(k % 4));
        end
        for (int k = 1; k < 5; k++) begin
            if (k < grant_cyc_log.size())
                check($sformatf("t2_gap%0d", k), 32'(grant_cyc_log[k] - grant_cyc_log[k-1]), 32'd4);
        end
        wait_idle();

        // T1 single job latency
        sb.push_back(mk(0, ERR_OK));
        issue(0, FUNC_RELU, 32'd16);
        check("t1_vin", 32'(act_valid_in), 32'd1);
        check("t1_size", act_matrix_size, 32'd16);
        check("t1_func", 32'(act_func_sel), 32'(FUNC_RELU));
        check("t1_busy", 32'(busy), 32'd1);
        step();
        check("t1_vout", 32'(act_valid_out), 32'd1);
        check("t1_vin_pulse", 32'(act_valid_in), 32'd0);
        check("t1_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        check("t1_rsp", 32'(rsp_valid), 32'd1);
        step();
        check("t1_rsp_drop", 32'(rsp_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);

        // T3 bad sizes never pulse the datapath; 196 is the largest legal size
        n = vin_count;
        sb.push_back(mk(2, ERR_SIZE));
        issue(2, FUNC_TANH, 32'd0);
        check("t3_rsp0", 32'(rsp_valid), 32'd1);
        check("t3_err0", 32'(rsp_err), 32'(ERR_SIZE));
        check("t3_hold_size", act_matrix_size, 32'd16);
        wait_idle();
        sb.push_back(mk(2, ERR_SIZE));
        issue(2, FUNC_TANH, 32'd197);
        check("t3_err197", 32'(rsp_err), 32'(ERR_SIZE));
        wait_idle();
        sb.push_back(mk(2, ERR_SIZE));
        issue(2, FUNC_TANH, 32'hFFFF_FFFF);
        wait_idle();
        check("t3_no_vin", 32'(vin_count - n), 32'd0);
        sb.push_back(mk(2, ERR_OK));
        issue(2, FUNC_SOFTMAX, 32'd196);
        check("t3_vin196", 32'(act_valid_in), 32'd1);
        check("t3_size196", act_matrix_size, 32'd196);
        wait_idle();

        // T4 timeout with response backpressure
        dp_en     = 1'b0;
        rsp_ready = 1'b0;
        sb.push_back(mk(1, ERR_TIMEOUT));
        issue(1, FUNC_SIGMOID, 32'd10);
        n = 0;
        while (!rsp_valid && n < 60) begin
            step();
            n++;
        end
        check("t4_latency", 32'(n), 32'(TIMEOUT + 1));
        check("t4_err", 32'(rsp_err), 32'(ERR_TIMEOUT));
        repeat (3) begin
            step();
            check("t4_busy_held", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        step();
        check("t4_released", 32'(busy), 32'd0);
        step();

        // T5 held response: stable fields, no grant while waiting
        dp_en     = 1'b1;
        rsp_ready = 1'b0;
        sb.push_back(mk(3, ERR_OK));
        issue(3, FUNC_SOFTMAX, 32'd196);
        step();
        step();
        sb.push_back(mk(0, ERR_OK));
        req_size[31:0] = 32'd20;
        req_func[1:0]  = FUNC_RELU;
        req_valid[0]   = 1'b1;
        #1;
        for (int k = 0; k < 5; k++) begin
            check("t5_rsp_valid", 32'(rsp_valid), 32'd1);
            check("t5_rsp_id", 32'(rsp_id), 32'd3);
            check("t5_rsp_err", 32'(rsp_err), 32'(ERR_OK));
            check("t5_no_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check("t5_rsp_drop", 32'(rsp_valid), 32'd0);
        check("t5_ready_after", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        wait_idle();

        // T5 collision: result arrives on the timeout cycle
        dp_en = 1'b0;
        sb.push_back(mk(1, ERR_OK));
        issue(1, FUNC_RELU, 32'd50);
        repeat (TIMEOUT) step();
        check("t5_still_wait", 32'(rsp_valid), 32'd0);
        force_vo = 1'b1;
        step();
        force_vo = 1'b0;
        check("t5_coll_rsp", 32'(rsp_valid), 32'd1);
        check("t5_coll_err", 32'(rsp_err), 32'(ERR_OK));
        wait_idle();

        // T6 reset mid-WAIT abandons the job; req0 then wins
        issue(2, FUNC_TANH, 32'd30);
        repeat (3) step();
        rst       = 1'b1;
        req_size  = {32'd12, 32'd12, 32'd12, 32'd12};
        req_valid = 4'hF;
        step();
        check("t6_req_ready", 32'(req_ready), 32'd0);
        check("t6_func", 32'(act_func_sel), 32'd0);
        check("t6_size", act_matrix_size, 32'd0);
        check("t6_vin", 32'(act_valid_in), 32'd0);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_rsp_id", 32'(rsp_id), 32'd0);
        check("t6_rsp_err", 32'(rsp_err), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        rst   = 1'b0;
        dp_en = 1'b1;
        sb.push_back(mk(0, ERR_OK));
        #1;
        check("t6_first_grant", 32'(req_ready), 32'd1);
        step();
        req_valid = '0;
        wait_idle();

        repeat (2) step();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
